usb_reg_sequencer: RTL and testbench
====================================

USB_REG_SEQUENCER -- requirements
Module: usb_reg_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max cycles per downstream phase before abort.
REQ-002 Parameter SKIP_EN, default 1, enables address-phase skipping via shadow index.
REQ-003 Port clk  in  1  single clock; all state rising-edge.
REQ-004 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port read_op / write_op  in  1 each  CPU register read/write request, held until bus_stall low.
REQ-006 Port bus_data_addr  in  32  CPU address; bits [9:2] = SL811 register index.
REQ-007 Port bus_data_write  in  32  CPU write data; bits [7:0] used.
REQ-008 Port bus_data_read  out  32  read result, byte replicated to all four lanes.
REQ-009 Port bus_stall  out  1  CPU stall.
REQ-010 Port usb_read_op / usb_write_op  out  1 each  one-cycle request pulses to USB controller.
REQ-011 Port usb_addr  out  32  32'h0 = address port, 32'h4 = data port.
REQ-012 Port usb_data_write  out  32  byte to controller, bits [31:8] zero.
REQ-013 Port usb_data_read  in  32  controller read data; bits [7:0] used.
REQ-014 Port usb_stall  in  1  controller busy; rises cycle after op pulse, falls at completion.

Function
REQ-015 States SHALL be IDLE, A_REQ, A_WAIT, D_REQ, D_WAIT, DONE.
REQ-016 IDLE: read_op has priority over write_op; latch idx=bus_data_addr[9:2], dir, wbyte=bus_data_write[7:0].
REQ-017 IDLE with request: go D_REQ if SKIP_EN and shadow_valid and idx==shadow_idx, else A_REQ.
REQ-018 A_REQ: one-cycle usb_write_op=1, usb_addr=32'h0, usb_data_write={24'h0,idx}; next A_WAIT.
REQ-019 *_WAIT: set seen flag when usb_stall=1; phase complete in first cycle with seen=1 and usb_stall=0.
REQ-020 A_WAIT completion -> D_REQ.
REQ-021 D_REQ: one-cycle usb_addr=32'h4 with usb_write_op (data=wbyte) or usb_read_op per dir; next D_WAIT.
REQ-022 D_WAIT completion: read -> bus_data_read<={4{usb_data_read[7:0]}}; write -> bus_data_read unchanged; shadow_idx<=idx+1 mod 256 (0xFF->0x00); shadow_valid<=1; next DONE.
REQ-023 Per-phase counter cleared on entering *_REQ, incremented each *_WAIT cycle; reaching TIMEOUT_CYCLES without completion -> DONE, shadow_valid<=0, read result 32'hFFFF_FFFF.
REQ-024 DONE: one cycle, then IDLE unconditionally; new request sampled no earlier than the following IDLE cycle.
REQ-025 bus_stall combinational = (state not IDLE and not DONE) or (state==IDLE and (read_op or write_op)).
REQ-026 bus_data_read valid in DONE and held until next completed read.
REQ-027 usb_read_op/usb_write_op never both high; high only in A_REQ/D_REQ.
REQ-028 Controller usb_stall high while IDLE SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, bus_data_read=32'h0, usb ops=0, usb_addr=32'h0, usb_data_write=32'h0, shadow_valid=0, counter=0, seen=0.
REQ-030 Reset mid-transaction abandons it; first post-reset access always issues address phase.

Verification
REQ-031 Write 0x5A to addr 0x0000_0014 after reset -> usb_write_op @32'h0 data 0x05, then usb_write_op @32'h4 data 0x5A; shadow_idx=0x06.
REQ-032 Read addr 0x18 following REQ-031 -> no address phase; single usb_read_op @32'h4; controller returns 0x3C -> bus_data_read=32'h3C3C_3C3C in DONE.
REQ-033 Read addr 0x3FC (idx 0xFF) then read addr 0x000 -> second read skips address phase (wrap to 0x00).
REQ-034 usb_stall never rises after D_REQ -> abort after 64 cycles, bus_data_read=32'hFFFF_FFFF, next access issues address phase.
REQ-035 Assert rst_n low during D_WAIT -> outputs at reset values same cycle; next access issues address phase.
REQ-036 read_op and write_op both high in IDLE -> read performed, no usb_write_op to 32'h4.

Source files
------------

// File: rtl/usb_reg_sequencer.sv
// Turns a CPU register access into SL811-style address-port/data-port cycles on a USB controller.
// A shadow of the next register index lets back-to-back sequential accesses skip the address phase.
module usb_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          SKIP_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_op,
  input  logic        write_op,
  input  logic [31:0] bus_data_addr,
  input  logic [31:0] bus_data_write,
  output logic [31:0] bus_data_read,
  output logic        bus_stall,
  output logic        usb_read_op,
  output logic        usb_write_op,
  output logic [31:0] usb_addr,
  output logic [31:0] usb_data_write,
  input  logic [31:0] usb_data_read,
  input  logic        usb_stall
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StAReq, StAWait, StDReq, StDWait, StDone} state_e;

  state_e          state_q;
  logic [7:0]      idx_q;
  logic [7:0]      wbyte_q;
  logic            dir_rd_q;
  logic [7:0]      shadow_idx_q;
  logic            shadow_valid_q;
  logic            seen_q;
  logic [CntW-1:0] cnt_q;

  logic       req;
  logic       hit;
  logic       phase_done;
  logic       phase_timeout;
  logic       d_rd;
  logic [7:0] d_wbyte;

  // Only the register index and the low bytes of the data buses are meaningful.
  logic unused_bits;
  assign unused_bits = ^{bus_data_addr[31:10], bus_data_addr[1:0], bus_data_write[31:8],
                         usb_data_read[31:8]};

  always_comb begin
    req           = read_op | write_op;
    hit           = SKIP_EN && shadow_valid_q && (bus_data_addr[9:2] == shadow_idx_q);
    phase_done    = seen_q & ~usb_stall;
    phase_timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    // Data-phase direction/byte come straight from the CPU when the address phase is skipped.
    d_rd          = (state_q == StIdle) ? read_op : dir_rd_q;
    d_wbyte       = (state_q == StIdle) ? bus_data_write[7:0] : wbyte_q;
    bus_stall     = ((state_q != StIdle) && (state_q != StDone)) || ((state_q == StIdle) && req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= 8'h0;
      wbyte_q        <= 8'h0;
      dir_rd_q       <= 1'b0;
      shadow_idx_q   <= 8'h0;
      shadow_valid_q <= 1'b0;
      seen_q         <= 1'b0;
      cnt_q          <= '0;
      bus_data_read  <= 32'h0;
      usb_read_op    <= 1'b0;
      usb_write_op   <= 1'b0;
      usb_addr       <= 32'h0;
      usb_data_write <= 32'h0;
    end else begin
      usb_read_op  <= 1'b0;
      usb_write_op <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q    <= bus_data_addr[9:2];
            dir_rd_q <= read_op;
            wbyte_q  <= bus_data_write[7:0];
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            if (hit) begin
              state_q      <= StDReq;
              usb_addr     <= 32'h4;
              usb_read_op  <= d_rd;
              usb_write_op <= ~d_rd;
              if (!d_rd) usb_data_write <= {24'h0, d_wbyte};
            end else begin
              state_q        <= StAReq;
              usb_addr       <= 32'h0;
              usb_write_op   <= 1'b1;
              usb_data_write <= {24'h0, bus_data_addr[9:2]};
            end
          end
        end
        StAReq: state_q <= StAWait;
        StAWait: begin
          if (phase_done) begin
            state_q      <= StDReq;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            usb_addr     <= 32'h4;
            usb_read_op  <= d_rd;
            usb_write_op <= ~d_rd;
            if (!d_rd) usb_data_write <= {24'h0, d_wbyte};
          end else if (phase_timeout) begin
            state_q        <= StDone;
            shadow_valid_q <= 1'b0;
            if (dir_rd_q) bus_data_read <= 32'hFFFF_FFFF;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (usb_stall) seen_q <= 1'b1;
          end
        end
        StDReq: state_q <= StDWait;
        StDWait: begin
          if (phase_done) begin
            state_q        <= StDone;
            shadow_idx_q   <= idx_q + 8'd1;
            shadow_valid_q <= 1'b1;
            if (dir_rd_q) bus_data_read <= {4{usb_data_read[7:0]}};
          end else if (phase_timeout) begin
            state_q        <= StDone;
            shadow_valid_q <= 1'b0;
            if (dir_rd_q) bus_data_read <= 32'hFFFF_FFFF;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (usb_stall) seen_q <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_reg_sequencer.sv
// Bench for usb_reg_sequencer: vector table of CPU accesses, controller model, and a scoreboard
// of expected controller cycles checked as each op pulse appears.
module tb_usb_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_op = 1'b0;
  logic        write_op = 1'b0;
  logic [31:0] bus_data_addr = 32'h0;
  logic [31:0] bus_data_write = 32'h0;
  logic [31:0] bus_data_read;
  logic        bus_stall;
  logic        usb_read_op;
  logic        usb_write_op;
  logic [31:0] usb_addr;
  logic [31:0] usb_data_write;
  logic [31:0] usb_data_read;
  logic        usb_stall;

  usb_reg_sequencer #(.TIMEOUT_CYCLES(64), .SKIP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .read_op(read_op), .write_op(write_op),
    .bus_data_addr(bus_data_addr), .bus_data_write(bus_data_write),
    .bus_data_read(bus_data_read), .bus_stall(bus_stall),
    .usb_read_op(usb_read_op), .usb_write_op(usb_write_op), .usb_addr(usb_addr),
    .usb_data_write(usb_data_write), .usb_data_read(usb_data_read), .usb_stall(usb_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Controller model: stall rises the cycle after an op pulse and stays up for 'lat' cycles.
  logic       silent = 1'b0;
  logic       stall_force = 1'b0;
  logic       stall_m;
  int         lat = 1;
  int         lat_cnt;
  logic [7:0] ctrl_byte = 8'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_m <= 1'b0;
      lat_cnt <= 0;
    end else if ((usb_read_op || usb_write_op) && !silent) begin
      stall_m <= 1'b1;
      lat_cnt <= lat;
    end else if (lat_cnt > 1) begin
      lat_cnt <= lat_cnt - 1;
    end else begin
      stall_m <= 1'b0;
      lat_cnt <= 0;
    end
  end

  assign usb_stall     = stall_m | stall_force;
  assign usb_data_read = {24'hC0FFEE, ctrl_byte};

  typedef struct {
    logic        is_read;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t sb[$];

  always @(negedge clk) begin
    if (rst_n && (usb_read_op || usb_write_op)) begin
      chk("op_exclusive", {31'h0, usb_read_op & usb_write_op}, 32'h0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_op: got rd=%b wr=%b addr=%h data=%h, want none",
                 usb_read_op, usb_write_op, usb_addr, usb_data_write);
      end else begin
        op_t e;
        e = sb.pop_front();
        chk("op_kind", {31'h0, usb_read_op}, {31'h0, e.is_read});
        chk("op_addr", usb_addr, e.addr);
        if (!e.is_read) chk("op_data", usb_data_write, e.data);
      end
    end
  end

  // One CPU access: expectations are queued first, then the request is held until bus_stall drops.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] rbyte, input logic skip,
                        input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    logic [31:0] a;
    a = addr;
    if (!skip) sb.push_back('{1'b0, 32'h0, {24'h0, a[9:2]}});
    sb.push_back('{rd, 32'h4, rd ? 32'h0 : {24'h0, wdata[7:0]}});
    ctrl_byte      = rbyte;
    bus_data_addr  = addr;
    bus_data_write = wdata;
    read_op        = rd;
    write_op       = wr;
    #1;
    cyc = 0;
    while (bus_stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (bus_stall) chk("stall_bound", {31'h0, bus_stall}, 32'h0);
    if (exp_cyc >= 0) chk("stall_cycles", cyc, exp_cyc);
    chk("bus_data_read", bus_data_read, exp_res);
    read_op  = 1'b0;
    write_op = 1'b0;
    chk("sb_drained", sb.size(), 32'h0);
    @(negedge clk);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  rbyte;
    logic        skip;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_005A, 8'h00, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0018, 32'h0000_0000, 8'h3C, 1'b1, 32'h3C3C_3C3C};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 8'h81, 1'b0, 32'h8181_8181};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'h11, 1'b1, 32'h1111_1111};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_00EE, 8'h77, 1'b1, 32'h7777_7777};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_00A5, 8'h00, 1'b0, 32'h7777_7777};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0104, 32'hFFFF_FF33, 8'h00, 1'b1, 32'h7777_7777};
    vecs[7] = '{1'b1, 1'b0, 32'hABCD_0108, 32'h0000_0000, 8'hC3, 1'b1, 32'hC3C3_C3C3};

    repeat (3) @(negedge clk);
    chk("rst_bus_data_read", bus_data_read, 32'h0);
    chk("rst_bus_stall", {31'h0, bus_stall}, 32'h0);
    chk("rst_usb_ops", {30'h0, usb_read_op, usb_write_op}, 32'h0);
    chk("rst_usb_addr", usb_addr, 32'h0);
    chk("rst_usb_data_write", usb_data_write, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      lat = 1 + (i % 4);
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rbyte,
             vecs[i].skip, vecs[i].res, -1);
    end

    // Silent controller on a skipped read: IDLE + D_REQ + 64 wait cycles, then abort.
    silent = 1'b1;
    do_txn(1'b1, 1'b0, 32'h0000_010C, 32'h0, 8'h00, 1'b1, 32'hFFFF_FFFF, 66);
    silent = 1'b0;
    lat    = 2;
    do_txn(1'b1, 1'b0, 32'h0000_010C, 32'h0, 8'h01, 1'b0, 32'h0101_0101, -1);

    // Reset asserted while the data phase is waiting on the controller.
    silent = 1'b1;
    sb.push_back('{1'b1, 32'h4, 32'h0});
    bus_data_addr = 32'h0000_0110;
    read_op       = 1'b1;
    for (int k = 0; k < 20 && !usb_read_op; k++) @(negedge clk);
    chk("reset_txn_reached_dreq", {31'h0, usb_read_op}, 32'h1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_bus_data_read", bus_data_read, 32'h0);
    chk("midrst_usb_ops", {30'h0, usb_read_op, usb_write_op}, 32'h0);
    chk("midrst_usb_addr", usb_addr, 32'h0);
    chk("midrst_usb_data_write", usb_data_write, 32'h0);
    read_op = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    silent = 1'b0;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 32'h0000_0114, 32'h0, 8'h2B, 1'b0, 32'h2B2B_2B2B, -1);

    // Controller stall while idle must not start anything.
    stall_force = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_stall_ignored", {31'h0, bus_stall}, 32'h0);
    stall_force = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 1'b1, 32'h0000_0118, 32'h0000_0055, 8'h00, 1'b1, 32'h2B2B_2B2B, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
